control_unit: RTL and testbench

- Multi-cycle instruction sequencer for the 8-bit CPU.
- Steps each instruction through FETCH, DECODE and EXECUTE.
- Drives ALU, register file, PC, IR, memory and datapath mux controls from the 4-bit opcode and the ALU zero/carry flags.
- Sits between the instruction register / flag register and the datapath.

---
 rtl/control_unit_if.sv | 28 ++
 rtl/control_unit.sv | 166 ++++++++++++++++
 tb/tb_control_unit.sv | 131 +++++++++++++
 3 files changed

// File: rtl/control_unit_if.sv
// Control bundle between the instruction sequencer and the CPU datapath.
// master: the sequencer (drives controls, reads opcode/flags); slave: the datapath.
interface control_unit_if;
    logic [3:0] opcode;
    logic       zero;
    logic       carry;
    logic [2:0] alu_op;
    logic       regfile_we;
    logic       pc_en;
    logic       pc_load;
    logic       ir_load;
    logic       mem_we;
    logic       mem_re;
    logic [1:0] sel_mux_a;
    logic [1:0] sel_mux_b;

    modport master (
        input  opcode, zero, carry,
        output alu_op, regfile_we, pc_en, pc_load, ir_load,
               mem_we, mem_re, sel_mux_a, sel_mux_b
    );

    modport slave (
        output opcode, zero, carry,
        input  alu_op, regfile_we, pc_en, pc_load, ir_load,
               mem_we, mem_re, sel_mux_a, sel_mux_b
    );
endinterface

// File: rtl/control_unit.sv
// FETCH/DECODE/EXECUTE sequencer, 3 cycles per instruction, no stalls; outputs combinational.
// CU_HALT_ON_ILLEGAL_EN: opcodes 1010-1111 park the sequencer in HALT until reset.
module control_unit (
    input  logic          clk,
    input  logic          rst,
    control_unit_if.master cu
);

`ifdef CU_HALT_ON_ILLEGAL_EN
    typedef enum logic [2:0] {
        INIT    = 3'b000,
        FETCH   = 3'b001,
        DECODE  = 3'b010,
        EXECUTE = 3'b011,
        HALT    = 3'b100
    } state_t;
`else
    typedef enum logic [1:0] {
        INIT    = 2'b00,
        FETCH   = 2'b01,
        DECODE  = 2'b10,
        EXECUTE = 2'b11
    } state_t;
`endif

    localparam logic [3:0] OP_NOP   = 4'b0000;
    localparam logic [3:0] OP_LDI   = 4'b0001;
    localparam logic [3:0] OP_MOV   = 4'b0010;
    localparam logic [3:0] OP_ADD   = 4'b0011;
    localparam logic [3:0] OP_SUB   = 4'b0100;
    localparam logic [3:0] OP_JMP   = 4'b0101;
    localparam logic [3:0] OP_JZ    = 4'b0110;
    localparam logic [3:0] OP_JC    = 4'b0111;
    localparam logic [3:0] OP_LOAD  = 4'b1000;
    localparam logic [3:0] OP_STORE = 4'b1001;

    localparam logic [2:0] ALU_PASS = 3'b000;
    localparam logic [2:0] ALU_ADD  = 3'b001;
    localparam logic [2:0] ALU_SUB  = 3'b010;

    localparam logic [1:0] A_ALU = 2'b00;
    localparam logic [1:0] A_IMM = 2'b01;
    localparam logic [1:0] A_MEM = 2'b10;
    localparam logic [1:0] A_SRC = 2'b11;

    localparam logic [1:0] B_REG = 2'b00;
    localparam logic [1:0] B_IMM = 2'b01;
    localparam logic [1:0] B_PC  = 2'b10;

    state_t     state;
    state_t     state_nxt;

    logic [2:0] alu_op;
    logic       regfile_we;
    logic       pc_en;
    logic       pc_load;
    logic       ir_load;
    logic       mem_we;
    logic       mem_re;
    logic [1:0] sel_mux_a;
    logic [1:0] sel_mux_b;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= INIT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        alu_op     = ALU_PASS;
        regfile_we = 1'b0;
        pc_en      = 1'b0;
        pc_load    = 1'b0;
        ir_load    = 1'b0;
        mem_we     = 1'b0;
        mem_re     = 1'b0;
        sel_mux_a  = A_ALU;
        sel_mux_b  = B_REG;

        case (state)
            INIT: begin
                state_nxt = FETCH;
            end
            FETCH: begin
                state_nxt = DECODE;
                mem_re    = 1'b1;
                ir_load   = 1'b1;
                pc_en     = 1'b1;
                sel_mux_b = B_PC;
            end
            DECODE: begin
                state_nxt = EXECUTE;
            end
            EXECUTE: begin
                state_nxt = FETCH;
                case (cu.opcode)
                    OP_NOP: ;
                    OP_LDI: begin
                        regfile_we = 1'b1;
                        sel_mux_a  = A_IMM;
                    end
                    OP_MOV: begin
                        regfile_we = 1'b1;
                        sel_mux_a  = A_SRC;
                        alu_op     = ALU_PASS;
                    end
                    OP_ADD: begin
                        regfile_we = 1'b1;
                        alu_op     = ALU_ADD;
                        sel_mux_a  = A_ALU;
                        sel_mux_b  = B_REG;
                    end
                    OP_SUB: begin
                        regfile_we = 1'b1;
                        alu_op     = ALU_SUB;
                        sel_mux_a  = A_ALU;
                        sel_mux_b  = B_REG;
                    end
                    OP_JMP:  pc_load = 1'b1;
                    // Flags feed pc_load directly so a late flag update lands this cycle.
                    OP_JZ:   pc_load = cu.zero;
                    OP_JC:   pc_load = cu.carry;
                    OP_LOAD: begin
                        mem_re     = 1'b1;
                        regfile_we = 1'b1;
                        sel_mux_a  = A_MEM;
                        sel_mux_b  = B_IMM;
                    end
                    OP_STORE: begin
                        mem_we    = 1'b1;
                        sel_mux_b = B_IMM;
                    end
                    default: begin
`ifdef CU_HALT_ON_ILLEGAL_EN
                        state_nxt = HALT;
`else
                        state_nxt = FETCH;
`endif
                    end
                endcase
            end
`ifdef CU_HALT_ON_ILLEGAL_EN
            HALT: begin
                state_nxt = HALT;
            end
`endif
            default: begin
                state_nxt = INIT;
            end
        endcase
    end

    assign cu.alu_op     = alu_op;
    assign cu.regfile_we = regfile_we;
    assign cu.pc_en      = pc_en;
    assign cu.pc_load    = pc_load;
    assign cu.ir_load    = ir_load;
    assign cu.mem_we     = mem_we;
    assign cu.mem_re     = mem_re;
    assign cu.sel_mux_a  = sel_mux_a;
    assign cu.sel_mux_b  = sel_mux_b;

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: steps hand-picked instructions and compares the packed control word.
module tb_control_unit;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    control_unit_if cu ();

    control_unit dut (
        .clk (clk),
        .rst (rst),
        .cu  (cu.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Control word: {alu_op[2:0], regfile_we, pc_en, pc_load, ir_load, mem_we, mem_re, sel_mux_a[1:0], sel_mux_b[1:0]}
    function automatic logic [12:0] cw(input logic [2:0] alu, input logic we, input logic pce,
                                       input logic pcl, input logic irl, input logic mwe,
                                       input logic mre, input logic [1:0] sa, input logic [1:0] sb);
        return {alu, we, pce, pcl, irl, mwe, mre, sa, sb};
    endfunction

    function automatic logic [12:0] observed();
        return {cu.alu_op, cu.regfile_we, cu.pc_en, cu.pc_load, cu.ir_load,
                cu.mem_we, cu.mem_re, cu.sel_mux_a, cu.sel_mux_b};
    endfunction

    task automatic chk(input string tag, input logic [12:0] got, input logic [12:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%b expected=%b", tag, got, exp);
        end
    endtask

    localparam logic [12:0] ZERO_CW  = 13'b0;
    localparam logic [12:0] FETCH_CW = 13'b000_0_1_0_1_0_1_00_10;

    // Entry: just after a negedge in FETCH. Exit: just after the negedge of the following FETCH.
    task automatic run_instr(input string tag, input logic [3:0] op, input logic z,
                             input logic c, input logic [12:0] exp);
        cu.opcode = op;
        cu.zero   = z;
        cu.carry  = c;
        chk({tag, "_fetch"}, observed(), FETCH_CW);
        @(negedge clk);
        chk({tag, "_decode"}, observed(), ZERO_CW);
        @(negedge clk);
        chk({tag, "_exec"}, observed(), exp);
        @(negedge clk);
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        cu.opcode = 4'b0000;
        cu.zero   = 1'b0;
        cu.carry  = 1'b0;

        repeat (2) @(negedge clk);
        chk("reset_hold", observed(), ZERO_CW);
        rst = 1'b0;
        #1 chk("init", observed(), ZERO_CW);
        @(negedge clk);

        run_instr("add",   4'b0011, 1'b0, 1'b0, 13'b001_1_0_0_0_0_0_00_00);
        run_instr("sub",   4'b0100, 1'b1, 1'b1, 13'b010_1_0_0_0_0_0_00_00);
        run_instr("ldi",   4'b0001, 1'b0, 1'b0, 13'b000_1_0_0_0_0_0_01_00);
        run_instr("mov",   4'b0010, 1'b0, 1'b0, 13'b000_1_0_0_0_0_0_11_00);
        run_instr("nop",   4'b0000, 1'b1, 1'b1, ZERO_CW);
        run_instr("load",  4'b1000, 1'b0, 1'b0, 13'b000_1_0_0_0_0_1_10_01);
        run_instr("store", 4'b1001, 1'b0, 1'b0, 13'b000_0_0_0_0_1_0_00_01);
        run_instr("jmp0",  4'b0101, 1'b0, 1'b0, 13'b000_0_0_1_0_0_0_00_00);
        run_instr("jmp1",  4'b0101, 1'b1, 1'b1, 13'b000_0_0_1_0_0_0_00_00);
        run_instr("jc0",   4'b0111, 1'b1, 1'b0, ZERO_CW);
        run_instr("jc1",   4'b0111, 1'b0, 1'b1, 13'b000_0_0_1_0_0_0_00_00);
        run_instr("jz_z1", 4'b0110, 1'b1, 1'b0, 13'b000_0_0_1_0_0_0_00_00);

        // JZ with the zero flag rising partway through EXECUTE
        run_instr("jz0",   4'b0110, 1'b0, 1'b1, ZERO_CW);
        cu.opcode = 4'b0110;
        cu.zero   = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("jz_late_pre", observed(), ZERO_CW);
        #2 cu.zero = 1'b1;
        #1 chk("jz_late_post", observed(), 13'b000_0_0_1_0_0_0_00_00);
        @(negedge clk);
        cu.zero = 1'b0;

        // Asynchronous reset in the middle of an ADD EXECUTE
        cu.opcode = 4'b0011;
        @(negedge clk);
        @(negedge clk);
        chk("add_pre_rst", observed(), 13'b001_1_0_0_0_0_0_00_00);
        #1 rst = 1'b1;
        #1 chk("rst_async", observed(), ZERO_CW);
        @(negedge clk);
        rst = 1'b0;
        #1 chk("init_after_rst", observed(), ZERO_CW);
        @(negedge clk);
        chk("fetch_after_rst", observed(), FETCH_CW);

`ifdef CU_HALT_ON_ILLEGAL_EN
        cu.opcode = 4'b1111;
        @(negedge clk);
        @(negedge clk);
        chk("ill_exec", observed(), ZERO_CW);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("halt_hold", observed(), ZERO_CW);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("fetch_after_halt", observed(), FETCH_CW);
`else
        run_instr("ill_f", 4'b1111, 1'b1, 1'b1, ZERO_CW);
        run_instr("ill_a", 4'b1010, 1'b0, 1'b0, ZERO_CW);
        chk("fetch_after_ill", observed(), FETCH_CW);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
